// File: rtl/mult_dot_accumulator.sv
// Dot-product accumulator: sums every VEC_LEN accepted products from the
// multiplier and presents each sum on a valid/ready output handshake.
// Optional saturating arithmetic with a sticky sat_flag port is enabled by
// defining MULT_DOT_ACC_SAT_EN; by default the sum wraps modulo 2^ACC_W.
module mult_dot_accumulator #(
  parameter int unsigned PROD_W  = 8,
  parameter int unsigned VEC_LEN = 4,
  parameter int unsigned ACC_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [3:0]        cnt_out
`ifdef MULT_DOT_ACC_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               sum_valid_q, sum_valid_d;
  logic [ACC_W-1:0]   add_res;
  logic               xfer;
`ifdef MULT_DOT_ACC_SAT_EN
  logic [SUM_W-1:0]   add_full;
  logic               add_carry;
  logic               ovf_q, ovf_d;
  logic               sat_q, sat_d;
`endif

  // Adder: running sum plus zero-extended product, saturating when enabled
  always_comb begin
`ifdef MULT_DOT_ACC_SAT_EN
    add_full  = SUM_W'(acc_q) + SUM_W'(prod_in);
    add_carry = add_full[ACC_W];
    add_res   = add_carry ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
    add_res   = acc_q + ACC_W'(prod_in);
`endif
  end

  // Next-state and datapath update; clear overrides everything
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
`ifdef MULT_DOT_ACC_SAT_EN
    ovf_d       = ovf_q;
    sat_d       = sat_q;
`endif
    prod_ready  = (state_q == ACCUM);
    xfer        = prod_valid && prod_ready;

    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      sum_d       = '0;
      sum_valid_d = 1'b0;
`ifdef MULT_DOT_ACC_SAT_EN
      ovf_d       = 1'b0;
      sat_d       = 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (xfer) begin
            if (cnt_q == LAST_CNT) begin
              sum_d       = add_res;
              sum_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              state_d     = HOLD;
`ifdef MULT_DOT_ACC_SAT_EN
              sat_d       = ovf_q | add_carry;
              ovf_d       = 1'b0;
`endif
            end else begin
              acc_d = add_res;
              cnt_d = cnt_q + CNT_W'(1);
`ifdef MULT_DOT_ACC_SAT_EN
              ovf_d = ovf_q | add_carry;
`endif
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            sum_valid_d = 1'b0;
            state_d     = ACCUM;
`ifdef MULT_DOT_ACC_SAT_EN
            sat_d       = 1'b0;
`endif
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
`ifdef MULT_DOT_ACC_SAT_EN
      ovf_q       <= 1'b0;
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
`ifdef MULT_DOT_ACC_SAT_EN
      ovf_q       <= ovf_d;
      sat_q       <= sat_d;
`endif
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;
  assign cnt_out   = cnt_q;
`ifdef MULT_DOT_ACC_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_mult_dot_accumulator.sv
// Directed bench for mult_dot_accumulator: a default-width instance and an
// ACC_W=9 instance share one input stream; the narrow one covers overflow.
module tb_mult_dot_accumulator;

  logic       clk;
  logic       rst_n;
  logic [7:0] prod_in;
  logic       prod_valid;
  logic       clear;
  logic       sum_ready;

  logic       prod_ready;
  logic [9:0] sum_out;
  logic       sum_valid;
  logic [3:0] cnt_out;

  logic       prod_ready9;
  logic [8:0] sum_out9;
  logic       sum_valid9;
  logic [3:0] cnt_out9;

`ifdef MULT_DOT_ACC_SAT_EN
  logic       sat_flag;
  logic       sat_flag9;
`endif

  int checks = 0;
  int errors = 0;

  mult_dot_accumulator #(.PROD_W(8), .VEC_LEN(4), .ACC_W(10)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .clear      (clear),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .cnt_out    (cnt_out)
`ifdef MULT_DOT_ACC_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  mult_dot_accumulator #(.PROD_W(8), .VEC_LEN(4), .ACC_W(9)) u_dut9 (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready9),
    .clear      (clear),
    .sum_out    (sum_out9),
    .sum_valid  (sum_valid9),
    .sum_ready  (sum_ready),
    .cnt_out    (cnt_out9)
`ifdef MULT_DOT_ACC_SAT_EN
    ,
    .sat_flag   (sat_flag9)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product for exactly one edge
  task automatic send(input logic [7:0] p);
    prod_valid = 1'b1;
    prod_in    = p;
    tick();
    prod_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    prod_in    = '0;
    prod_valid = 1'b0;
    clear      = 1'b0;
    sum_ready  = 1'b0;
    #1;
    chk("rst_sum_valid",  32'(sum_valid),  32'd0);
    chk("rst_cnt",        32'(cnt_out),    32'd0);
    chk("rst_prod_ready", 32'(prod_ready), 32'd1);
    chk("rst_sum_out",    32'(sum_out),    32'd0);
    #12;
    rst_n = 1'b1;
    tick();

    // Reset mid-vector after two products
    send(8'd3);
    send(8'd4);
    chk("mid_cnt_before_rst", 32'(cnt_out), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt",   32'(cnt_out),   32'd0);
    chk("mid_rst_valid", 32'(sum_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    send(8'd1); send(8'd1); send(8'd1); send(8'd1);
    chk("mid_sum_valid",  32'(sum_valid),  32'd1);
    chk("mid_sum_out",    32'(sum_out),    32'd4);
    chk("mid_prod_ready", 32'(prod_ready), 32'd0);
    sum_ready = 1'b1;
    tick();
    chk("mid_hs_valid", 32'(sum_valid),  32'd0);
    chk("mid_hs_ready", 32'(prod_ready), 32'd1);

    // Basic vector with downstream always ready
    send(8'd10);
    chk("basic_cnt1", 32'(cnt_out), 32'd1);
    send(8'd30); send(8'd0); send(8'd225);
    chk("basic_valid",      32'(sum_valid),  32'd1);
    chk("basic_sum",        32'(sum_out),    32'd265);
    chk("basic_ready_low",  32'(prod_ready), 32'd0);
    chk("basic_cnt0",       32'(cnt_out),    32'd0);
    tick();
    chk("basic_valid_drop", 32'(sum_valid),  32'd0);
    chk("basic_ready_high", 32'(prod_ready), 32'd1);

    // Backpressure with a held product
    sum_ready = 1'b0;
    send(8'd10); send(8'd30); send(8'd0); send(8'd225);
    prod_valid = 1'b1;
    prod_in    = 8'd7;
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum",   32'(sum_out),    32'd265);
      chk("bp_valid", 32'(sum_valid),  32'd1);
      chk("bp_ready", 32'(prod_ready), 32'd0);
      tick();
    end
    chk("bp_cnt_held", 32'(cnt_out), 32'd0);
    sum_ready = 1'b1;
    tick();
    chk("bp_hs_valid",   32'(sum_valid),  32'd0);
    chk("bp_hs_cnt",     32'(cnt_out),    32'd0);
    chk("bp_hs_ready",   32'(prod_ready), 32'd1);
    tick();
    prod_valid = 1'b0;
    chk("bp_7_taken", 32'(cnt_out), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("bp_clear_cnt", 32'(cnt_out), 32'd0);

    // Gapped input stream
    send(8'd5); chk("gap_cnt_a", 32'(cnt_out), 32'd1);
    tick();     chk("gap_cnt_b", 32'(cnt_out), 32'd1);
    tick();     chk("gap_cnt_c", 32'(cnt_out), 32'd1);
    send(8'd2); chk("gap_cnt_d", 32'(cnt_out), 32'd2);
    tick();     chk("gap_cnt_e", 32'(cnt_out), 32'd2);
    send(8'd3); chk("gap_cnt_f", 32'(cnt_out), 32'd3);
    send(8'd4); chk("gap_cnt_g", 32'(cnt_out), 32'd0);
    chk("gap_sum",   32'(sum_out),   32'd14);
    chk("gap_valid", 32'(sum_valid), 32'd1);
    tick();

    // Clear with a product presented in the same cycle
    send(8'd100); send(8'd100);
    chk("clr_cnt_pre", 32'(cnt_out), 32'd2);
    prod_valid = 1'b1;
    prod_in    = 8'd50;
    clear      = 1'b1;
    tick();
    prod_valid = 1'b0;
    clear      = 1'b0;
    chk("clr_cnt",   32'(cnt_out),   32'd0);
    chk("clr_valid", 32'(sum_valid), 32'd0);
    chk("clr_sum",   32'(sum_out),   32'd0);
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    chk("clr_sum_after", 32'(sum_out),   32'd10);
    chk("clr_valid_aft", 32'(sum_valid), 32'd1);
    tick();

    // Overflow: four products of 225 (900 total)
    sum_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    send(8'd225); send(8'd225); send(8'd225); send(8'd225);
    chk("ovf_wide_sum", 32'(sum_out),    32'd900);
    chk("ovf_valid9",   32'(sum_valid9), 32'd1);
`ifdef MULT_DOT_ACC_SAT_EN
    chk("ovf_sum9_sat",  32'(sum_out9),  32'd511);
    chk("ovf_sat9",      32'(sat_flag9), 32'd1);
    chk("ovf_sat_wide",  32'(sat_flag),  32'd0);
`else
    chk("ovf_sum9_wrap", 32'(sum_out9),  32'd388);
`endif
    sum_ready = 1'b1;
    tick();
    chk("ovf_hs_valid9", 32'(sum_valid9), 32'd0);
`ifdef MULT_DOT_ACC_SAT_EN
    chk("ovf_sat9_clr",  32'(sat_flag9),  32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
